// File: rtl/adder_arb_pkg.sv
// Shared constants and types for the shared-adder arbiter.
package adder_arb_pkg;

    localparam int NREQ_DEFAULT = 4;

    // Conventional requester slots.
    localparam int REQ_PC  = 0;
    localparam int REQ_BR  = 1;
    localparam int REQ_ALU = 2;
    localparam int REQ_LSU = 3;

    // Output register occupancy.
    typedef enum logic {
        StEmpty,
        StFull
    } rsp_state_e;

    // Width of a requester ID; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder.sv
// Combinational modular adder; the carry-out is discarded.
module adder #(
    parameter int WIDTH = 63
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan N slots starting at ptr; the first valid one wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// One signed adder shared by NREQ valid/ready requesters under round-robin
// arbitration; result, winner ID and signed overflow are registered.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = 63,
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int IDW   = id_width(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*(WIDTH+1)-1:0] req_a,
    input  logic [NREQ*(WIDTH+1)-1:0] req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH:0]            rsp_sum,
    output logic [IDW-1:0]            rsp_id,
    output logic                      rsp_ovf
);

    rsp_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_next, winner;
    logic [NREQ-1:0] gnt;
    logic           can_accept, xfer, ovf;
    logic [WIDTH:0] a_sel, b_sel, sum;

    // Accept when empty, or when the held result drains this cycle.
    assign can_accept = (state_q == StEmpty) || rsp_ready;

    rr_arbiter #(
        .N  (NREQ),
        .PW (IDW)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Grants are held off while reset is asserted, even though the FSM reads EMPTY.
    assign req_ready = (can_accept && rst_n) ? gnt : '0;
    assign xfer      = |req_ready;

    // Operand mux and winner encode driven by the one-hot grant.
    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel  = req_a[i*(WIDTH+1) +: WIDTH+1];
                b_sel  = req_b[i*(WIDTH+1) +: WIDTH+1];
                winner = IDW'(i);
            end
        end
    end

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum)
    );

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign ovf      = (a_sel[WIDTH] == b_sel[WIDTH]) && (sum[WIDTH] != a_sel[WIDTH]);
    assign ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

    // Occupancy next-state: a transfer always fills, a bare drain empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (xfer) state_d = StFull;
            StFull: begin
                if (xfer) begin
                    state_d = StFull;
                end else if (rsp_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Occupancy, priority pointer and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            rsp_sum <= '0;
            rsp_id  <= '0;
            rsp_ovf <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                ptr_q   <= ptr_next;
                rsp_sum <= sum;
                rsp_id  <= winner;
                rsp_ovf <= ovf;
            end
        end
    end

    assign rsp_valid = (state_q == StFull);

    grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one combinational signed adder (two's-complement, modular) among NREQ requesters.
- Typical requesters: PC increment, branch target, ALU add, load/store address generation.
- Each requester uses a valid/ready handshake; a round-robin arbiter grants one requester per cycle.
- The selected operands are summed, and the result is registered with the winner's ID and a signed-overflow flag.

Parameters:
- WIDTH, 63, MSB index of the data path; operand and sum buses are WIDTH+1 bits.
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NREQ  requester i has operands ready.
- req_a  input  NREQ*(WIDTH+1)  packed operand A; requester i occupies bits [i*(WIDTH+1) +: WIDTH+1].
- req_b  input  NREQ*(WIDTH+1)  packed operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant; the operands of requester i are accepted this cycle.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result this cycle.
- rsp_sum  output  WIDTH+1  a+b modulo 2^(WIDTH+1).
- rsp_id  output  IDW  index of the requester that produced rsp_sum.
- rsp_ovf  output  1  signed overflow of the addition.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_ovf=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - req_ready=0 while reset is asserted.
- Output register state machine, two states:
  - EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
  - can_accept = EMPTY | (FULL & rsp_ready).
- Grant, combinational:
  - When can_accept is true, pick the first valid requester scanning from the pointer upward, wrapping NREQ-1 to 0.
  - req_ready is one-hot for the winner; all zero if no request is valid or can_accept is false.
  - req_ready never depends on req_a or req_b.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - A requester must hold valid and operands stable until its transfer.
  - Dropping valid before the grant is legal; the request is simply withdrawn.
- Latency: one cycle. A transfer at edge N gives rsp_valid=1 with the sum after edge N.
- At the clock edge:
  - If a transfer occurs: rsp_sum <= a+b, rsp_id <= winner, rsp_ovf <= (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), rsp_valid <= 1, pointer <= (winner+1) mod NREQ.
  - Else if FULL & rsp_ready: rsp_valid <= 0. rsp_sum, rsp_id and rsp_ovf hold their last values.
  - Else: everything holds, and the pointer does not move.
- Throughput:
  - Full throughput is one result per cycle.
  - A drain and a new transfer in the same cycle is a back-to-back update, with no bubble.
- Backpressure: while FULL & !rsp_ready, there are no grants and rsp_* stay stable.
- Arithmetic:
  - Wrap-around is modular; the carry-out is discarded.
  - rsp_ovf flags signed overflow only; unsigned carry is not reported.
- Fairness: a requester that stays valid is granted within NREQ accepting cycles.
- Reset mid-operation: any pending result is discarded and the pointer returns to 0. No partial transfer is visible after rst_n deasserts.
- Tooling: no X on outputs after reset; assertions check that req_ready is one-hot or zero.

Decomposition:
- Package adder_arb_pkg:
  - Default NREQ.
  - Requester index constants: REQ_PC=0, REQ_BR=1, REQ_ALU=2, REQ_LSU=3.
  - ID width helper.
- Sub-module rr_arbiter (parameter N): inputs req and ptr, output one-hot gnt. Purely combinational; the pointer register lives in adder_arbiter.
- The existing adder module is instantiated once with WIDTH passed through. The overflow logic sits in adder_arbiter.

Test Plan:
- Reset, then a single request: req_valid=0001, a0=5, b0=7 → req_ready=0001; next cycle rsp_valid=1, rsp_sum=12, rsp_id=0, rsp_ovf=0.
- Round robin: all four valid and rsp_ready=1 held → grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3,0; one result every cycle.
- Backpressure:
  - Setup: rsp_valid=1, rsp_ready=0 for 3 cycles, req_valid=0110.
  - Required: req_ready=0 and rsp_* stable during the stall.
  - On rsp_ready=1, requester 1 is granted first (pointer=1 after the previous grant to 0).
- Overflow and wrap:
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1 → rsp_sum=0x8000_0000_0000_0000, rsp_ovf=1.
  - a=0xFFFF_FFFF_FFFF_FFFF, b=1 → rsp_sum=0, rsp_ovf=0.
  - a=-3, b=-4 → rsp_sum=-7, rsp_ovf=0.
- Withdrawal and skip: pointer=2, req_valid=1001 → grant requester 3, then requester 0; requester 2 dropping valid before its grant produces no response.
- Async reset mid-stream: assert rst_n=0 between edges while FULL → rsp_valid falls immediately to 0 (no clock needed); after release, req_valid=1111 grants requester 0 first.
